// File: rtl/shacc_seq.sv
// rtl/shacc_seq.sv - bit-plane shift-accumulate sequencer, N channels; SHACC_SEQ_SAT_EN enables per-update saturation
module shacc_seq #(
    parameter int W    = 32,
    parameter int A    = 8,
    parameter int N    = 4,
    parameter int PMAX = 16,
    localparam int PW  = $clog2(PMAX + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            start,
    input  logic [PW-1:0]   prec,
    input  logic            msb_neg,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*A-1:0]  I,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  O,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   prec_q, prec_d;
    logic            neg_q, neg_d;
    logic [N*W-1:0]  acc_q, acc_d;
    logic [N*W-1:0]  acc_upd;
    logic            first_neg;

    // Only the first plane of a two's-complement operand carries negative weight
    assign first_neg = (cnt_q == '0) && neg_q;

`ifdef SHACC_SEQ_SAT_EN
    localparam logic signed [W+1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};
`endif

    for (genvar c = 0; c < N; c++) begin : g_ch
        logic [W-1:0] acc_c;
        assign acc_c = acc_q[c*W +: W];
`ifdef SHACC_SEQ_SAT_EN
        // Full-precision 2*acc +/- I, then clamp back into W bits
        logic signed [W+1:0] dbl_c, opnd_c, full_c;
        assign dbl_c  = {acc_c[W-1], acc_c, 1'b0};
        assign opnd_c = (W+2)'($signed(I[c*A +: A]));
        assign full_c = first_neg ? (dbl_c - opnd_c) : (dbl_c + opnd_c);
        assign acc_upd[c*W +: W] = (full_c > SAT_MAX) ? SAT_MAX[W-1:0] :
                                   (full_c < SAT_MIN) ? SAT_MIN[W-1:0] :
                                   full_c[W-1:0];
`else
        // Plain modulo-2^W shift-accumulate, confined to this channel's slice
        logic [W-1:0] dbl_c, opnd_c;
        assign dbl_c  = acc_c << 1;
        assign opnd_c = W'($signed(I[c*A +: A]));
        assign acc_upd[c*W +: W] = first_neg ? (dbl_c - opnd_c) : (dbl_c + opnd_c);
`endif
    end

    // State, counters and accumulators; reset discards any sequence in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prec_q  <= PW'(1);
            neg_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prec_q  <= prec_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state: latch config on start, accumulate accepted beats, clr overrides all
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prec_d  = prec_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (prec == '0)
                        prec_d = PW'(1);
                    else if (prec > PW'(PMAX))
                        prec_d = PW'(PMAX);
                    else
                        prec_d = prec;
                    neg_d   = msb_neg;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_d = acc_upd;
                    cnt_d = cnt_q + PW'(1);
                    if (cnt_q == prec_q - PW'(1))
                        state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign O         = acc_q;

endmodule

// File: tb/tb_shacc_seq.sv
// tb/tb_shacc_seq.sv - scoreboard testbench for shacc_seq
module tb_shacc_seq;
    localparam int W = 32, A = 8, N = 4, PMAX = 16, PW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, clr, start, msb_neg, in_valid, out_ready;
    logic [PW-1:0]   prec;
    logic [N*A-1:0]  I;
    logic            in_ready, out_valid, busy;
    logic [N*W-1:0]  O;

    logic            s_start, s_in_valid, s_in_ready, s_out_valid, s_busy;
    logic [7:0]      s_I, s_O;

    int tests = 0;
    int fails = 0;
    logic [N*W-1:0] sb[$];
    int bv[16][4];

    logic watch_busy = 1'b0, seen_busy = 1'b0, busy_drop = 1'b0;

    shacc_seq #(.W(W), .A(A), .N(N), .PMAX(PMAX)) dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .prec(prec),
        .msb_neg(msb_neg), .in_valid(in_valid), .in_ready(in_ready), .I(I),
        .out_valid(out_valid), .out_ready(out_ready), .O(O), .busy(busy)
    );

    shacc_seq #(.W(8), .A(8), .N(1), .PMAX(PMAX)) s_dut (
        .clk(clk), .rst(rst), .clr(clr), .start(s_start), .prec(prec),
        .msb_neg(msb_neg), .in_valid(s_in_valid), .in_ready(s_in_ready), .I(s_I),
        .out_valid(s_out_valid), .out_ready(out_ready), .O(s_O), .busy(s_busy)
    );

    always @(negedge clk) begin
        if (watch_busy) begin
            if (busy) seen_busy <= 1'b1;
            else if (seen_busy) busy_drop <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bv();
        for (int k = 0; k < 16; k++)
            for (int c = 0; c < N; c++) bv[k][c] = 0;
    endtask

    task automatic rand_bv();
        for (int k = 0; k < 16; k++)
            for (int c = 0; c < N; c++) bv[k][c] = int'($urandom_range(255)) - 128;
    endtask

    // Drive start and nb beats; expected value is the weighted plane sum mod 2^W
    task automatic run_seq(input int p, input bit neg, input int nb, input int gap, input bit push);
        int pe;
        longint e, v;
        logic [N*W-1:0] exp;
        pe = (p == 0) ? 1 : ((p > PMAX) ? PMAX : p);
        if (push) begin
            exp = '0;
            for (int c = 0; c < N; c++) begin
                e = 0;
                for (int k = 0; k < pe; k++) begin
                    v = longint'(bv[k][c]);
                    if (k == 0 && neg) v = -v;
                    e = e + v * (longint'(1) << (pe - 1 - k));
                end
                exp[c*W +: W] = e[W-1:0];
            end
            sb.push_back(exp);
        end
        prec = p[PW-1:0];
        msb_neg = neg;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < nb; k++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            for (int c = 0; c < N; c++) I[c*A +: A] = A'(bv[k][c]);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 100) begin
            if (out_valid === 1'b1) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got %b want 000", {in_ready, out_valid, busy});
        end
        tests++;
        if (O !== '0) begin
            fails++;
            $display("FAIL reset_O: got %h want 0", O);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        logic [N*W-1:0] exp, got;
        clear_bv();
        bv[0][0] = 1; bv[1][0] = 0; bv[2][0] = 1; bv[3][0] = 1;
        out_ready = 1'b1;
        run_seq(4, 1'b0, 4, 0, 1'b1);
        wait_out(ok);
        exp = sb.pop_front();
        got = O;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL basic_timeout: got no out_valid want out_valid");
        end
        tests++;
        if (got !== exp || got[31:0] !== 32'd11) begin
            fails++;
            $display("FAIL basic_O: got %h want %h", got, exp);
        end
        tick();
        tests++;
        if ({out_valid, busy} !== 2'b00 || O !== exp) begin
            fails++;
            $display("FAIL basic_idle_retain: got ov/busy %b O %h want 00 O %h", {out_valid, busy}, O, exp);
        end
    endtask

    task automatic test_signed();
        bit ok;
        logic [N*W-1:0] exp;
        rand_bv();
        bv[0][1] = 1; bv[1][1] = 1; bv[2][1] = 0; bv[3][1] = 1;
        run_seq(4, 1'b1, 4, 0, 1'b1);
        wait_out(ok);
        exp = sb.pop_front();
        tests++;
        if (!ok || O !== exp || O[63:32] !== 32'hFFFF_FFFD) begin
            fails++;
            $display("FAIL signed_msb_neg: got %h want %h (ok=%0d)", O, exp, ok);
        end
        tick();
        rand_bv();
        bv[0][2] = -4; bv[1][2] = 9;
        run_seq(2, 1'b0, 2, 0, 1'b1);
        wait_out(ok);
        exp = sb.pop_front();
        tests++;
        if (!ok || O !== exp || O[95:64] !== 32'd1) begin
            fails++;
            $display("FAIL signed_prec2: got %h want %h (ok=%0d)", O, exp, ok);
        end
        tick();
    endtask

    task automatic test_gaps();
        bit ok;
        logic [N*W-1:0] exp;
        rand_bv();
        out_ready = 1'b0;
        watch_busy = 1'b1;
        run_seq(4, 1'b1, 4, 3, 1'b1);
        wait_out(ok);
        exp = sb.pop_front();
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL gaps_timeout: got no out_valid want out_valid");
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || O !== exp) begin
                fails++;
                $display("FAIL gaps_hold%0d: got ov %b busy %b O %h want 1 1 %h", i, out_valid, busy, O, exp);
            end
            tick();
        end
        watch_busy = 1'b0;
        tests++;
        if (busy_drop !== 1'b0 || seen_busy !== 1'b1) begin
            fails++;
            $display("FAIL gaps_busy: got drop %b seen %b want 0 1", busy_drop, seen_busy);
        end
        out_ready = 1'b1;
        tick();
        tick();
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || O !== exp) begin
            fails++;
            $display("FAIL gaps_release: got ov %b busy %b O %h want 0 0 %h", out_valid, busy, O, exp);
        end
    endtask

    task automatic test_clr();
        bit seen;
        clear_bv();
        bv[0][0] = 5; bv[1][0] = 3; bv[2][0] = 7; bv[3][0] = 2;
        run_seq(4, 1'b0, 2, 0, 1'b0);
        tests++;
        if (O[31:0] !== 32'd13) begin
            fails++;
            $display("FAIL clr_partial: got %0d want 13", O[31:0]);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || O !== '0) begin
            fails++;
            $display("FAIL clr_abort: got busy %b ov %b O %h want 0 0 0", busy, out_valid, O);
        end
        seen = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid || busy) seen = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL clr_no_output: got activity want none");
        end
        start = 1'b1;
        clr = 1'b1;
        tick();
        start = 1'b0;
        clr = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL clr_over_start: got busy %b want 0", busy);
        end
    endtask

    task automatic test_async_rst();
        bit seen;
        rand_bv();
        bv[0][3] = 17;
        run_seq(4, 1'b0, 2, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || O !== '0) begin
            fails++;
            $display("FAIL rst_async: got busy %b ir %b O %h want 0 0 0", busy, in_ready, O);
        end
        #2;
        rst = 1'b0;
        tick();
        seen = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid || busy) seen = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_output: got activity want none");
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        logic [N*W-1:0] exp;
        exp = '0;
        exp[31:0] = 32'd11;
        sb.push_back(exp);
        I = '0;
        out_ready = 1'b0;
        prec = 5'd2;
        msb_neg = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        I[7:0] = 8'd3;
        tick();
        in_valid = 1'b0;
        prec = 5'd7;
        msb_neg = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        I[7:0] = 8'd5;
        tick();
        in_valid = 1'b0;
        wait_out(ok);
        exp = sb.pop_front();
        tests++;
        if (!ok || O !== exp) begin
            fails++;
            $display("FAIL start_in_acc: got %h want %h (ok=%0d)", O, exp, ok);
        end
        prec = 5'd1;
        start = 1'b1;
        in_valid = 1'b1;
        I[7:0] = 8'd99;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || O !== exp) begin
            fails++;
            $display("FAIL start_in_done: got ov %b O %h want 1 %h", out_valid, O, exp);
        end
        out_ready = 1'b1;
        tick();
        rand_bv();
        run_seq(0, 1'b0, 1, 0, 1'b1);
        wait_out(ok);
        exp = sb.pop_front();
        tests++;
        if (!ok || O !== exp) begin
            fails++;
            $display("FAIL prec0: got %h want %h (ok=%0d)", O, exp, ok);
        end
        tick();
        rand_bv();
        run_seq(31, 1'b1, 16, 0, 1'b1);
        wait_out(ok);
        exp = sb.pop_front();
        tests++;
        if (!ok || O !== exp) begin
            fails++;
            $display("FAIL prec_clamp: got %h want %h (ok=%0d)", O, exp, ok);
        end
        tick();
    endtask

    task automatic test_sat();
        logic [7:0] exp;
        int n;
`ifdef SHACC_SEQ_SAT_EN
        exp = 8'd127;
`else
        exp = 8'hBC;
`endif
        out_ready = 1'b1;
        prec = 5'd3;
        msb_neg = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_in_valid = 1'b1;
        s_I = 8'd100;
        for (int k = 0; k < 3; k++) tick();
        s_in_valid = 1'b0;
        n = 0;
        while (s_out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (s_out_valid !== 1'b1 || s_O !== exp) begin
            fails++;
            $display("FAIL sat_w8: got ov %b O %0d want 1 %0d", s_out_valid, $signed(s_O), $signed(exp));
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; start = 1'b0; msb_neg = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; prec = '0; I = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_I = '0;
        test_reset();
        test_basic();
        test_signed();
        test_gaps();
        test_clr();
        test_async_rst();
        test_start_ignored();
        test_sat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
